// File: rtl/sampqueue.sv
// Sample queue: buffers wide samples in a circular FIFO and serialises them
// LSB-byte-first onto an 8-bit valid/ready stream, counting overflow drops.
module sampqueue #(
    parameter int SAMPLE_W   = 72,
    parameter int DEPTH_BITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    output logic                  sq_active,
    input  logic [SAMPLE_W-1:0]   sample,
    input  logic                  sample_avail,
    output logic [7:0]            data_out,
    output logic                  data_valid,
    input  logic                  data_ready,
    output logic [DEPTH_BITS:0]   level,
    output logic [15:0]           overflow_count
);

    localparam int NB    = SAMPLE_W / 8;
    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [IDX_W-1:0]    LAST_IDX   = IDX_W'(NB - 1);
    localparam logic [DEPTH_BITS:0] FULL_LEVEL = (DEPTH_BITS+1)'(DEPTH);

    typedef enum logic {S_EMPTY, S_SEND} state_t;

    state_t                  state_reg, state_next;
    logic                    sq_active_reg;
    logic [15:0]             ovf_reg;
    logic [DEPTH_BITS-1:0]   wptr_reg, rptr_reg;
    logic [DEPTH_BITS:0]     level_reg, level_next;
    logic [SAMPLE_W-1:0]     shift_reg;
    logic [IDX_W-1:0]        idx_reg;
    logic [SAMPLE_W-1:0]     mem [DEPTH];

    logic push_try, full, push_ok, last_accept, pop;

    always_comb begin
        push_try    = sample_avail && sq_active_reg;
        full        = (level_reg == FULL_LEVEL);
        push_ok     = push_try && !full;
        last_accept = (state_reg == S_SEND) && data_ready && (idx_reg == LAST_IDX);
        // The serialiser refills either from idle or on the final byte accept,
        // so consecutive samples stream without a bubble.
        pop         = (level_reg != '0) && ((state_reg == S_EMPTY) || last_accept);
    end

    always_comb begin
        level_next = level_reg;
        case ({push_ok, pop})
            2'b10:   level_next = level_reg + 1'b1;
            2'b01:   level_next = level_reg - 1'b1;
            default: level_next = level_reg;
        endcase
    end

    // Sample storage has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wptr_reg] <= sample;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_reg <= S_EMPTY;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_EMPTY: if (pop) state_next = S_SEND;
            S_SEND:  if (last_accept && !pop) state_next = S_EMPTY;
            default: state_next = S_EMPTY;
        endcase
    end

    always_comb begin
        data_valid     = (state_reg == S_SEND);
        data_out       = shift_reg[{idx_reg, 3'b000} +: 8];
        sq_active      = sq_active_reg;
        level          = level_reg;
        overflow_count = ovf_reg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sq_active_reg <= 1'b0;
            ovf_reg       <= '0;
            wptr_reg      <= '0;
            rptr_reg      <= '0;
            level_reg     <= '0;
            shift_reg     <= '0;
            idx_reg       <= '0;
        end else begin
            sq_active_reg <= enable;
            if (enable && !sq_active_reg)
                ovf_reg <= '0;
            else if (push_try && full && ovf_reg != 16'hFFFF)
                ovf_reg <= ovf_reg + 16'd1;
            if (push_ok)
                wptr_reg <= wptr_reg + 1'b1;
            level_reg <= level_next;
            if (pop) begin
                shift_reg <= mem[rptr_reg];
                rptr_reg  <= rptr_reg + 1'b1;
                idx_reg   <= '0;
            end else if ((state_reg == S_SEND) && data_ready && (idx_reg != LAST_IDX)) begin
                idx_reg <= idx_reg + 1'b1;
            end
        end
    end

endmodule
